// File: rtl/riscv_pkg.sv
// Shared RISC-V lane definitions: widths, ALU control codes, operand-stage state and entry layout.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 4;
  localparam int REG_AW = 5;
  localparam int PERF_W = 16;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b1100;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } stage_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_pc;
    logic              use_imm;
  } op_entry_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decoded-op, write-back and ALU-side bus of the operand stage.
interface alu_operand_stage_if;
  import riscv_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_alu_ctrl;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [XLEN-1:0]   in_rs1_val;
  logic [XLEN-1:0]   in_rs2_val;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_imm;
  logic              in_use_pc;
  logic              in_use_imm;
  logic [REG_AW-1:0] in_rd;
  logic              in_we;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_a;
  logic [XLEN-1:0]   out_b;
  logic [CTRL_W-1:0] out_alu_ctrl;
  logic [REG_AW-1:0] out_rd;
  logic              out_we;
  logic [PERF_W-1:0] perf_stall;

  modport slave (
    input  in_valid, in_alu_ctrl, in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_pc, in_imm,
           in_use_pc, in_use_imm, in_rd, in_we, wb_valid, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_we, perf_stall
  );

  modport master (
    output in_valid, in_alu_ctrl, in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_pc, in_imm,
           in_use_pc, in_use_imm, in_rd, in_we, wb_valid, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_we, perf_stall
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// Write-back bypass for one source operand; x0 is never forwarded.
module operand_fwd_mux
  import riscv_pkg::*;
(
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   val,
  output logic [XLEN-1:0]   fwd_val
);

  // select write-back data when it targets this non-zero source register
  always_comb begin
    if (wb_valid && (wb_rd == rs) && (rs != {REG_AW{1'b0}})) begin
      fwd_val = wb_data;
    end else begin
      fwd_val = val;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: captures decoded ops, bypasses write-back data and feeds the ALU
// from a registered two-entry skid buffer, counting downstream back-pressure cycles.
module alu_operand_stage
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  alu_operand_stage_if.slave  bus
);

  localparam logic [PERF_W-1:0] STALL_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] STALL_MAX = {PERF_W{1'b1}};

  stage_state_e      state_q, state_d;
  op_entry_t         head_q, head_d, skid_q, skid_d;
  op_entry_t         cap_s, head_ref_s, skid_ref_s;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic              push_s, pop_s;
  logic [XLEN-1:0]   cap_a_fwd_s, cap_b_fwd_s, head_a_fwd_s, head_b_fwd_s, skid_a_fwd_s, skid_b_fwd_s;

  operand_fwd_mux u_fwd_cap_a (.wb_valid(bus.wb_valid), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
                               .rs(bus.in_rs1), .val(bus.in_rs1_val), .fwd_val(cap_a_fwd_s));
  operand_fwd_mux u_fwd_cap_b (.wb_valid(bus.wb_valid), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
                               .rs(bus.in_rs2), .val(bus.in_rs2_val), .fwd_val(cap_b_fwd_s));
  operand_fwd_mux u_fwd_head_a (.wb_valid(bus.wb_valid), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
                                .rs(head_q.rs1), .val(head_q.a), .fwd_val(head_a_fwd_s));
  operand_fwd_mux u_fwd_head_b (.wb_valid(bus.wb_valid), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
                                .rs(head_q.rs2), .val(head_q.b), .fwd_val(head_b_fwd_s));
  operand_fwd_mux u_fwd_skid_a (.wb_valid(bus.wb_valid), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
                                .rs(skid_q.rs1), .val(skid_q.a), .fwd_val(skid_a_fwd_s));
  operand_fwd_mux u_fwd_skid_b (.wb_valid(bus.wb_valid), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
                                .rs(skid_q.rs2), .val(skid_q.b), .fwd_val(skid_b_fwd_s));

  // build the incoming entry and the write-back-refreshed copies of both held entries
  always_comb begin
    cap_s.a       = bus.in_use_pc  ? bus.in_pc  : cap_a_fwd_s;
    cap_s.b       = bus.in_use_imm ? bus.in_imm : cap_b_fwd_s;
    cap_s.ctrl    = bus.in_alu_ctrl;
    cap_s.rd      = bus.in_rd;
    cap_s.we      = bus.in_we;
    cap_s.rs1     = bus.in_rs1;
    cap_s.rs2     = bus.in_rs2;
    cap_s.use_pc  = bus.in_use_pc;
    cap_s.use_imm = bus.in_use_imm;
    head_ref_s    = head_q;
    head_ref_s.a  = head_q.use_pc  ? head_q.a : head_a_fwd_s;
    head_ref_s.b  = head_q.use_imm ? head_q.b : head_b_fwd_s;
    skid_ref_s    = skid_q;
    skid_ref_s.a  = skid_q.use_pc  ? skid_q.a : skid_a_fwd_s;
    skid_ref_s.b  = skid_q.use_imm ? skid_q.b : skid_b_fwd_s;
  end

  assign push_s = bus.in_valid & in_ready_q;
  assign pop_s  = out_valid_q & bus.out_ready;

  // occupancy FSM next state, entry movement and stall counter
  always_comb begin
    state_d = state_q;
    head_d  = head_ref_s;
    skid_d  = skid_ref_s;
    stall_d = stall_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d = ST_ONE;
            head_d  = cap_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            state_d = ST_ONE;
            head_d  = cap_s;
          end else if (push_s) begin
            state_d = ST_TWO;
            skid_d  = cap_s;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            state_d = ST_ONE;
            head_d  = skid_ref_s;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
      if (out_valid_q && !bus.out_ready && (stall_q != STALL_MAX)) begin
        stall_d = stall_q + STALL_ONE;
      end else begin
        stall_d = stall_q;
      end
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // state, entries and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      stall_q     <= {PERF_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      stall_q     <= stall_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_a        = head_q.a;
  assign bus.out_b        = head_q.b;
  assign bus.out_alu_ctrl = head_q.ctrl;
  assign bus.out_rd       = head_q.rd;
  assign bus.out_we       = head_q.we;
  assign bus.perf_stall   = stall_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_alu_operand_stage;
  import riscv_pkg::*;

  typedef struct {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_pc;
    logic              use_imm;
  } ent_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_pass;
  ent_t mq[$];
  int   m_stall;

  logic [CTRL_W-1:0] ctrl_tab [9];

  alu_operand_stage_if bus ();

  alu_operand_stage dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] rs, input logic [XLEN-1:0] val);
    if (bus.wb_valid && bus.wb_rd == rs && rs != 5'd0) return bus.wb_data;
    return val;
  endfunction

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_alu_ctrl = 4'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
    bus.in_rs1_val = 32'd0; bus.in_rs2_val = 32'd0; bus.in_pc = 32'd0; bus.in_imm = 32'd0;
    bus.in_use_pc = 1'b0; bus.in_use_imm = 1'b0; bus.in_rd = 5'd0; bus.in_we = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
  endtask

  task automatic put_op(input logic [CTRL_W-1:0] ctrl, input logic [REG_AW-1:0] rs1,
                        input logic [XLEN-1:0] v1, input logic [REG_AW-1:0] rs2,
                        input logic [XLEN-1:0] v2, input logic [REG_AW-1:0] rd);
    bus.in_valid = 1'b1; bus.in_alu_ctrl = ctrl; bus.in_rs1 = rs1; bus.in_rs1_val = v1;
    bus.in_rs2 = rs2; bus.in_rs2_val = v2; bus.in_rd = rd; bus.in_we = (rd != 5'd0);
    bus.in_use_pc = 1'b0; bus.in_use_imm = 1'b0;
  endtask

  task automatic check_outputs();
    check("in_ready", bus.in_ready, (mq.size() < 2));
    check("out_valid", bus.out_valid, (mq.size() != 0));
    check("perf_stall", bus.perf_stall, m_stall);
    if (mq.size() != 0) begin
      check("out_a", bus.out_a, mq[0].a);
      check("out_b", bus.out_b, mq[0].b);
      check("out_ctrl", bus.out_alu_ctrl, mq[0].ctrl);
      check("out_rd", bus.out_rd, mq[0].rd);
      check("out_we", bus.out_we, mq[0].we);
    end
  endtask

  // reference: the stage is a 2-deep FIFO whose register-sourced operands track write-back
  task automatic model_edge();
    int   n;
    bit   do_push, do_pop;
    ent_t e;
    n = mq.size();
    if (flush) begin
      mq.delete();
      return;
    end
    if (n != 0 && !bus.out_ready && m_stall != 65535) m_stall++;
    do_push = bus.in_valid && (n < 2);
    do_pop  = (n != 0) && bus.out_ready;
    e.rs1 = bus.in_rs1; e.rs2 = bus.in_rs2; e.ctrl = bus.in_alu_ctrl;
    e.rd = bus.in_rd; e.we = bus.in_we; e.use_pc = bus.in_use_pc; e.use_imm = bus.in_use_imm;
    e.a = bus.in_use_pc  ? bus.in_pc  : fwd(bus.in_rs1, bus.in_rs1_val);
    e.b = bus.in_use_imm ? bus.in_imm : fwd(bus.in_rs2, bus.in_rs2_val);
    foreach (mq[i]) begin
      if (!mq[i].use_pc)  mq[i].a = fwd(mq[i].rs1, mq[i].a);
      if (!mq[i].use_imm) mq[i].b = fwd(mq[i].rs2, mq[i].b);
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_a"}, bus.out_a, 32'd0);
    check({tag, "_out_b"}, bus.out_b, 32'd0);
    check({tag, "_out_ctrl"}, bus.out_alu_ctrl, 4'd0);
    check({tag, "_out_rd"}, bus.out_rd, 5'd0);
    check({tag, "_out_we"}, bus.out_we, 1'b0);
    check({tag, "_perf"}, bus.perf_stall, 16'd0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; m_stall = 0;
    ctrl_tab = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL};
    rst_n = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    idle();
    #12;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // basic add push with downstream ready
    bus.out_ready = 1'b1;
    put_op(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd10);
    step();
    check("t1_out_valid", bus.out_valid, 1'b1);
    check("t1_out_a", bus.out_a, 32'd5);
    check("t1_out_b", bus.out_b, 32'd7);
    check("t1_ctrl", bus.out_alu_ctrl, 4'b0000);
    idle(); step();

    // two ops under back-pressure, then drain in order
    bus.out_ready = 1'b0;
    put_op(ALU_SUB, 5'd4, 32'h11, 5'd5, 32'h22, 5'd6); step();
    put_op(ALU_XOR, 5'd7, 32'h33, 5'd8, 32'h44, 5'd9); step();
    idle();
    check("t2_in_ready", bus.in_ready, 1'b0);
    step(); step();
    bus.out_ready = 1'b1;
    step(); step(); step();

    // forwarding at capture, and x0 never forwarded
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hDEAD;
    put_op(ALU_OR, 5'd3, 32'h1, 5'd2, 32'h2, 5'd1); step();
    check("t3_fwd_a", bus.out_a, 32'hDEAD);
    bus.wb_rd = 5'd0; bus.wb_data = 32'hBEEF;
    put_op(ALU_AND, 5'd0, 32'h55, 5'd0, 32'h66, 5'd1); step();
    check("t3_x0_a", bus.out_a, 32'h55);
    idle(); step();

    // held op refreshed by a later write-back
    bus.out_ready = 1'b0;
    put_op(ALU_ADD, 5'd1, 32'h1, 5'd9, 32'h11, 5'd2); step();
    idle(); step(); step();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h1234; step();
    idle();
    check("t4_refresh_b", bus.out_b, 32'h1234);
    bus.out_ready = 1'b1; step(); idle(); step();

    // AUIPC-style pc/imm operands ignore forwarding
    put_op(ALU_ADD, 5'd4, 32'h7, 5'd5, 32'h8, 5'd3);
    bus.in_use_pc = 1'b1; bus.in_use_imm = 1'b1; bus.in_pc = 32'h100; bus.in_imm = 32'h2000;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'hFFFF;
    bus.out_ready = 1'b0; step();
    idle(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hAAAA; step();
    check("t5_a_pc", bus.out_a, 32'h100);
    check("t5_b_imm", bus.out_b, 32'h2000);
    idle(); bus.out_ready = 1'b1; step(); step();

    // flush from TWO with a same-cycle push
    bus.out_ready = 1'b0;
    put_op(ALU_SLL, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3); step();
    put_op(ALU_SRL, 5'd1, 32'h3, 5'd2, 32'h4, 5'd3); step();
    flush = 1'b1; put_op(ALU_SLT, 5'd1, 32'h5, 5'd2, 32'h6, 5'd3); step();
    flush = 1'b0; idle();
    check("t6_flush_valid", bus.out_valid, 1'b0);
    check("t6_flush_ready", bus.in_ready, 1'b1);
    step();

    // asynchronous reset in the middle of a stall
    put_op(ALU_SUB, 5'd1, 32'h9, 5'd2, 32'hA, 5'd3); step();
    put_op(ALU_SUB, 5'd1, 32'hB, 5'd2, 32'hC, 5'd3); step();
    idle(); step();
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    mq.delete(); m_stall = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // random traffic
    for (int c = 0; c < 600; c++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.in_alu_ctrl = ctrl_tab[$urandom_range(0, 8)];
      bus.in_rs1      = 5'($urandom_range(0, 3));
      bus.in_rs2      = 5'($urandom_range(0, 3));
      bus.in_rs1_val  = $urandom;
      bus.in_rs2_val  = $urandom;
      bus.in_pc       = $urandom;
      bus.in_imm      = $urandom;
      bus.in_use_pc   = ($urandom_range(0, 4) == 0);
      bus.in_use_imm  = ($urandom_range(0, 3) == 0);
      bus.in_rd       = 5'($urandom);
      bus.in_we       = 1'($urandom);
      bus.wb_valid    = 1'($urandom);
      bus.wb_rd       = 5'($urandom_range(0, 3));
      bus.wb_data     = $urandom;
      bus.out_ready   = ($urandom_range(0, 2) != 0);
      flush           = ($urandom_range(0, 31) == 0);
      step();
    end
    flush = 1'b0; idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
